// File: rtl/uart_sched_pkg.sv
// Shared types and elaboration helpers for the UART transmit scheduler.
// Also used by its interface and its round-robin arbiter.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_LOAD = 3'd2,
      ST_BUSY = 3'd3,
      ST_GAP  = 3'd4
   } sched_state_e;

   // Ceiling log2, clamped to 1 so derived vectors never collapse to zero width.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((32'd1 << width) < value) begin
         width = width + 1;
      end
      return (width < 1) ? 1 : width;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer-side and UART-side signals of the transmit scheduler.
// The scheduler takes the master view and the environment takes the slave view.
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   import uart_sched_pkg::*;

   localparam int ID_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         uart_din;
   logic                      uart_write_enable;
   logic                      uart_tx_busy;
   logic [ID_W-1:0]           grant_id;
   logic                      grant_active;
   logic                      err_timeout;

   modport master (
      input  req_valid, req_data, uart_tx_busy,
      output req_ready, uart_din, uart_write_enable, grant_id, grant_active, err_timeout
   );

   modport slave (
      output req_valid, req_data, uart_tx_busy,
      input  req_ready, uart_din, uart_write_enable, grant_id, grant_active, err_timeout
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
// The design keeps it free of state so the receive side can reuse it.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   logic found;
   logic hit;
   int   idx;

   // Rotate the search start to rr_ptr and keep the first hit only.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = |req;
      found     = 1'b0;
      hit       = 1'b0;
      idx       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx            = int'(rr_ptr) + off;
         idx            = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
         hit            = !found && req[idx];
         grant[idx]     = hit;
         grant_idx      = hit ? ID_W'(idx) : grant_idx;
         found          = found | hit;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers:
// one byte per grant, write_enable held until tx_busy, then an inter-frame gap.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int GAP_CYCLES  = 16,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_scheduler_if.master bus
);

   localparam int ID_W  = clog2(NUM_REQ);
   localparam int CNT_W = clog2(max2(ACK_TIMEOUT, GAP_CYCLES) + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? CNT_W'(0) : CNT_W'(GAP_CYCLES - 1);

   sched_state_e       state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  din_q, din_d;
   logic               we_q, we_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               grant_active_q, grant_active_d;
   logic               err_q, err_d;
   logic [NUM_REQ-1:0] req_ready_s;

   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;
   logic [DATA_W-1:0]  sel_byte;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + CNT_W'(1);
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_valid (arb_any)
   );

   assign sel_byte = bus.req_data[int'(arb_idx)*DATA_W +: DATA_W];

   // Next-state and output logic; req_ready is combinational so the pulse lands in the ARB cycle itself.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      cnt_d          = cnt_q;
      din_d          = din_q;
      we_d           = we_q;
      grant_id_d     = grant_id_q;
      grant_active_d = grant_active_q;
      err_d          = 1'b0;
      req_ready_s    = '0;
      case (state_q)
         ST_IDLE: begin
            // A frame left running by a reset must finish before any new grant.
            if (!bus.uart_tx_busy && arb_any) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (arb_any) begin
               req_ready_s    = arb_grant;
               din_d          = sel_byte;
               grant_id_d     = arb_idx;
               grant_active_d = 1'b1;
               rr_ptr_d       = (arb_idx == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : arb_idx + ID_W'(1);
               cnt_d          = '0;
               we_d           = 1'b1;
               state_d        = ST_LOAD;
            end else begin
               state_d        = ST_IDLE;
            end
         end
         ST_LOAD: begin
            // Busy is tested first so an acknowledge on the last timeout cycle still counts.
            if (bus.uart_tx_busy) begin
               we_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end else if (cnt_q >= ACK_LAST) begin
               we_d    = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d   = sat_inc(cnt_q);
            end
         end
         ST_BUSY: begin
            if (!bus.uart_tx_busy) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_GAP: begin
            if (cnt_q >= GAP_LAST) begin
               grant_active_d = 1'b0;
               cnt_d          = '0;
               state_d        = ST_IDLE;
            end else begin
               cnt_d          = sat_inc(cnt_q);
            end
         end
         default: begin
            state_d        = ST_IDLE;
            we_d           = 1'b0;
            grant_active_d = 1'b0;
            cnt_d          = '0;
         end
      endcase
   end

   // State, counter and registered outputs; reset drops any in-flight byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         cnt_q          <= '0;
         din_q          <= '0;
         we_q           <= 1'b0;
         grant_id_q     <= '0;
         grant_active_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         cnt_q          <= cnt_d;
         din_q          <= din_d;
         we_q           <= we_d;
         grant_id_q     <= grant_id_d;
         grant_active_q <= grant_active_d;
         err_q          <= err_d;
      end
   end

   assign bus.req_ready         = req_ready_s;
   assign bus.uart_din          = din_q;
   assign bus.uart_write_enable = we_q;
   assign bus.grant_id          = grant_id_q;
   assign bus.grant_active      = grant_active_q;
   assign bus.err_timeout       = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: instance A (GAP 16) with a behavioural UART model, instance B (GAP 0)
// with the busy line driven directly to hit the acknowledge/timeout coincidence.
module tb_uart_tx_scheduler;

   localparam int FRAME = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) ifa ();
   uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) ifb ();

   uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(16), .ACK_TIMEOUT(1024)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .ACK_TIMEOUT(1024)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   always #5 clk = ~clk;

   // UART model for A: loads on write_enable while idle, stays busy for FRAME cycles.
   logic       busy_a_mdl = 1'b0;
   int         frame_cnt_a = 0;
   logic [7:0] cap_a = 8'h00;
   bit         ack_en_a = 1'b1;

   always @(posedge clk) begin
      if (busy_a_mdl) begin
         if (frame_cnt_a == 0) busy_a_mdl <= 1'b0;
         else frame_cnt_a <= frame_cnt_a - 1;
      end else if (ack_en_a && ifa.uart_write_enable) begin
         busy_a_mdl  <= 1'b1;
         frame_cnt_a <= FRAME - 1;
         cap_a       <= ifa.uart_din;
      end
   end
   assign ifa.uart_tx_busy = busy_a_mdl;

   int n_assert = 0;
   int n_fail = 0;
   int ready_cnt[4] = '{0, 0, 0, 0};
   int err_cnt_a = 0;
   int err_cnt_b = 0;
   int low_run = 0;
   int last_low_run = 0;
   logic prev_busy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 4; i++) ready_cnt[i] += int'(ifa.req_ready[i]);
      err_cnt_a += int'(ifa.err_timeout);
      err_cnt_b += int'(ifb.err_timeout);
      if (ifa.uart_tx_busy) begin
         if (!prev_busy) last_low_run = low_run;
         low_run = 0;
      end else begin
         low_run++;
      end
      prev_busy = ifa.uart_tx_busy;
   endtask

   // One complete grant on A: ready pulse, load, acknowledge, write_enable release.
   task automatic serve(input int idx, input logic [7:0] b, input bit gapchk);
      int w;
      w = 0;
      while (ifa.req_ready == 4'b0000 && w < 200) begin step(); w++; end
      chk("ready_within_bound", 32'(w < 200), 32'd1);
      chk("req_ready_onehot", 32'(ifa.req_ready), 32'd1 << idx);
      step();
      chk("we_after_ready", 32'(ifa.uart_write_enable), 32'd1);
      chk("din_byte", 32'(ifa.uart_din), 32'(b));
      chk("grant_id", 32'(ifa.grant_id), 32'(idx));
      chk("grant_active", 32'(ifa.grant_active), 32'd1);
      chk("ready_single_pulse", 32'(ifa.req_ready), 32'd0);
      w = 0;
      while (!ifa.uart_tx_busy && w < 2000) begin step(); w++; end
      chk("busy_within_bound", 32'(w < 2000), 32'd1);
      chk("we_held_to_busy", 32'(ifa.uart_write_enable), 32'd1);
      chk("uart_captured", 32'(cap_a), 32'(b));
      if (gapchk) chk("idle_gap_len", 32'(last_low_run), 32'd20);
      step();
      chk("we_released", 32'(ifa.uart_write_enable), 32'd0);
   endtask

   initial begin
      int w;
      int cnt;
      int early;
      ifa.req_valid = 4'b0000;
      ifa.req_data  = 32'h0;
      ifb.req_valid = 4'b0000;
      ifb.req_data  = 32'h0;
      ifb.uart_tx_busy = 1'b0;

      // Reset values
      #1 rst_n = 1'b0;
      step(); step(); step();
      chk("rst_we", 32'(ifa.uart_write_enable), 32'd0);
      chk("rst_din", 32'(ifa.uart_din), 32'd0);
      chk("rst_ready", 32'(ifa.req_ready), 32'd0);
      chk("rst_grant_id", 32'(ifa.grant_id), 32'd0);
      chk("rst_grant_active", 32'(ifa.grant_active), 32'd0);
      chk("rst_err", 32'(ifa.err_timeout), 32'd0);
      chk("rst_b_we", 32'(ifb.uart_write_enable), 32'd0);
      rst_n = 1'b1;

      // Fairness: all valid continuously, order 0,1,2,3,0,1,2,3
      ifa.req_data  = {8'hC0, 8'hFF, 8'h7E, 8'h3C};
      ifa.req_valid = 4'b1111;
      serve(0, 8'h3C, 1'b0);
      serve(1, 8'h7E, 1'b1);
      serve(2, 8'hFF, 1'b1);
      serve(3, 8'hC0, 1'b1);
      serve(0, 8'h3C, 1'b1);
      serve(1, 8'h7E, 1'b1);
      serve(2, 8'hFF, 1'b1);
      serve(3, 8'hC0, 1'b1);
      for (int i = 0; i < 4; i++) chk("ready_count_per_req", 32'(ready_cnt[i]), 32'd2);

      // Wrap: last grant 3, only 1 and 3 valid -> 1 then 3
      ifa.req_valid = 4'b1010;
      serve(1, 8'h7E, 1'b1);
      serve(3, 8'hC0, 1'b1);
      ifa.req_valid = 4'b0000;
      w = 0;
      while (ifa.grant_active && w < 200) begin step(); w++; end
      chk("idle_after_wrap", 32'(ifa.grant_active), 32'd0);

      // Single request on 2 with 0xA5, then measure the gap
      ifa.req_data  = {8'hC0, 8'hA5, 8'h7E, 8'h3C};
      ifa.req_valid = 4'b0100;
      cnt = ready_cnt[2];
      serve(2, 8'hA5, 1'b0);
      ifa.req_valid = 4'b0000;
      chk("single_ready_once", 32'(ready_cnt[2] - cnt), 32'd1);
      w = 0;
      while (ifa.uart_tx_busy && w < 100) begin step(); w++; end
      cnt = 0;
      while (ifa.grant_active && cnt < 100) begin step(); cnt++; end
      chk("gap_busy_fall_to_release", 32'(cnt), 32'd17);

      // Timeout: UART never acknowledges
      ack_en_a = 1'b0;
      ifa.req_data  = {8'h96, 8'hA5, 8'h7E, 8'h5A};
      ifa.req_valid = 4'b0001;
      w = 0;
      while (ifa.req_ready == 4'b0000 && w < 200) begin step(); w++; end
      chk("to_ready", 32'(ifa.req_ready), 32'd1);
      step();
      ifa.req_valid = 4'b0000;
      cnt = 0;
      while (ifa.uart_write_enable && cnt < 2000) begin cnt++; step(); end
      chk("to_we_high_cycles", 32'(cnt), 32'd1024);
      chk("to_err_pulse", 32'(ifa.err_timeout), 32'd1);
      chk("to_err_count", 32'(err_cnt_a), 32'd1);
      step();
      chk("to_err_single", 32'(ifa.err_timeout), 32'd0);
      chk("to_still_in_gap", 32'(ifa.grant_active), 32'd1);
      ack_en_a = 1'b1;
      ifa.req_valid = 4'b1000;
      serve(3, 8'h96, 1'b0);
      ifa.req_valid = 4'b0000;
      chk("to_err_total", 32'(err_cnt_a), 32'd1);

      // Reset mid-frame, then the pending 0xD5 is resent once busy falls
      w = 0;
      while (ifa.grant_active && w < 200) begin step(); w++; end
      ifa.req_data  = {8'h96, 8'hA5, 8'h7E, 8'hD5};
      ifa.req_valid = 4'b0001;
      serve(0, 8'hD5, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 32'(ifa.uart_write_enable), 32'd0);
      chk("mid_rst_din", 32'(ifa.uart_din), 32'd0);
      chk("mid_rst_grant_active", 32'(ifa.grant_active), 32'd0);
      chk("mid_rst_grant_id", 32'(ifa.grant_id), 32'd0);
      chk("mid_rst_busy_kept", 32'(ifa.uart_tx_busy), 32'd1);
      step(); step();
      rst_n = 1'b1;
      early = 0;
      w = 0;
      while (ifa.uart_tx_busy && w < 100) begin
         if (ifa.req_ready != 4'b0000 || ifa.grant_active) early++;
         step(); w++;
      end
      chk("no_grant_while_busy", 32'(early), 32'd0);
      step();
      chk("regrant_after_busy", 32'(ifa.req_ready), 32'd1);
      serve(0, 8'hD5, 1'b0);
      ifa.req_valid = 4'b0000;

      // GAP_CYCLES=0 build: busy on the last timeout cycle, then back-to-back frame
      ifb.req_data  = {8'h00, 8'h00, 8'hFA, 8'h7B};
      ifb.req_valid = 4'b0011;
      w = 0;
      while (ifb.req_ready == 4'b0000 && w < 200) begin step(); w++; end
      chk("b_ready0", 32'(ifb.req_ready), 32'd1);
      step();
      chk("b_din0", 32'(ifb.uart_din), 32'h7B);
      cnt = int'(ifb.uart_write_enable);
      for (int k = 1; k < 1024; k++) begin
         step();
         cnt += int'(ifb.uart_write_enable);
      end
      chk("b_we_high_until_last", 32'(cnt), 32'd1024);
      ifb.uart_tx_busy = 1'b1;
      step();
      chk("b_coincident_we_off", 32'(ifb.uart_write_enable), 32'd0);
      chk("b_coincident_no_err", 32'(ifb.err_timeout), 32'd0);
      step(); step(); step();
      chk("b_no_err_total", 32'(err_cnt_b), 32'd0);
      ifb.uart_tx_busy = 1'b0;
      step();
      chk("b_gap_we_low", 32'(ifb.uart_write_enable), 32'd0);
      step();
      chk("b_idle_no_ready", 32'(ifb.req_ready), 32'd0);
      step();
      chk("b_ready1", 32'(ifb.req_ready), 32'd2);
      step();
      chk("b_we_reasserted", 32'(ifb.uart_write_enable), 32'd1);
      chk("b_din1", 32'(ifb.uart_din), 32'hFA);
      chk("b_grant_id1", 32'(ifb.grant_id), 32'd1);
      ifb.req_valid = 4'b0000;
      ifb.uart_tx_busy = 1'b1;
      step(); step();
      ifb.uart_tx_busy = 1'b0;
      step(); step();
      chk("b_err_final", 32'(err_cnt_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
